// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control FSM.
// Optional feature macro: MC_CTRL_BNE_EN (adds the bne instruction and its BNE state).
package mc_ctrl_pkg;

    localparam int unsigned STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`ifdef MC_CTRL_BNE_EN
        S_JUMP   = 4'd11,
        S_BNE    = 4'd12
`else
        S_JUMP   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the control FSM knows how to sequence.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MC_CTRL_BNE_EN
        legal = legal || (op == OP_BNE);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the main control FSM and the multicycle datapath.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero,
        output pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, state_dbg
    );

    modport slave (
        output opcode, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, aluop, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// State to control-word decode; only illegal_op and the branch pcen look past the state.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pcen,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op
);

    // Control word per state; everything held low while reset is asserted.
    always_comb begin
        pcen       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    alusrcb = SRCB_FOUR;
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                end
                S_DECODE: begin
                    alusrcb    = SRCB_IMMSH;
                    illegal_op = !op_is_legal(opcode);
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BEQ: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = PCSRC_ALUOUT;
                    pcen    = zero;
                end
`ifdef MC_CTRL_BNE_EN
                S_BNE: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = PCSRC_ALUOUT;
                    pcen    = !zero;
                end
`endif
                S_ADDIWB: regwrite = 1'b1;
                S_JUMP: begin
                    pcsrc = PCSRC_JUMP;
                    pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core: state register and next-state logic.
// Optional feature macro: MC_CTRL_BNE_EN (bne sequenced like beq with inverted zero).
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus
);

    state_t             state_q;
    state_t             state_d;
    logic [STATE_W-1:0] state_raw;

    // Next state from current state and, in DECODE/MEMADR only, the opcode.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_raw     = state_q;
    assign bus.state_dbg = state_raw;

    mc_ctrl_outdec u_outdec (
        .reset      (reset),
        .state      (state_q),
        .opcode     (bus.opcode),
        .zero       (bus.zero),
        .pcen       (bus.pcen),
        .irwrite    (bus.irwrite),
        .memwrite   (bus.memwrite),
        .regwrite   (bus.regwrite),
        .iord       (bus.iord),
        .regdst     (bus.regdst),
        .memtoreg   (bus.memtoreg),
        .alusrca    (bus.alusrca),
        .alusrcb    (bus.alusrcb),
        .pcsrc      (bus.pcsrc),
        .aluop      (bus.aluop),
        .illegal_op (bus.illegal_op)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm; honours MC_CTRL_BNE_EN when defined.
// Control word layout used below:
//   [14]pcen [13]irwrite [12]memwrite [11]regwrite [10]iord [9]regdst [8]memtoreg
//   [7]alusrca [6:5]alusrcb [4:3]pcsrc [2:1]aluop [0]illegal_op
module tb_mc_ctrl_fsm;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mc_ctrl_if bus_if ();

    mc_ctrl_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] cw_now();
        return {bus_if.pcen, bus_if.irwrite, bus_if.memwrite, bus_if.regwrite,
                bus_if.iord, bus_if.regdst, bus_if.memtoreg, bus_if.alusrca,
                bus_if.alusrcb, bus_if.pcsrc, bus_if.aluop, bus_if.illegal_op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.opcode = 6'b100011;
        bus_if.zero = 1'b0;
        tick();
        tick();
        n_checks++;
        if (cw_now() !== 15'h0000) $display("FAIL reset_cw got %h exp %h", cw_now(), 15'h0000);
        else n_pass++;
        n_checks++;
        if (bus_if.state_dbg !== 4'd0) $display("FAIL reset_state got %0d exp 0", bus_if.state_dbg);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_if.state_dbg !== 4'd0) $display("FAIL release_state got %0d exp 0", bus_if.state_dbg);
        else n_pass++;
        n_checks++;
        if (cw_now() !== 15'h6020) $display("FAIL release_cw got %h exp %h", cw_now(), 15'h6020);
        else n_pass++;
    endtask

    task automatic test_lw();
        logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [14:0] cw [5] = '{15'h6020, 15'h0060, 15'h00C0, 15'h0400, 15'h0900};
        bus_if.opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus_if.state_dbg !== st[i]) $display("FAIL lw_state cyc%0d got %0d exp %0d", i, bus_if.state_dbg, st[i]);
            else n_pass++;
            n_checks++;
            if (cw_now() !== cw[i]) $display("FAIL lw_cw cyc%0d got %h exp %h", i, cw_now(), cw[i]);
            else n_pass++;
            tick();
        end
    endtask

    // R-type, sw and addi are all four-cycle instructions; zero is held high to show it is ignored.
    task automatic test_four_cycle();
        logic [5:0]  ops [3]    = '{6'b000000, 6'b101011, 6'b001000};
        logic [3:0]  st  [3][4] = '{'{4'd0, 4'd1, 4'd6, 4'd7},
                                    '{4'd0, 4'd1, 4'd2, 4'd5},
                                    '{4'd0, 4'd1, 4'd9, 4'd10}};
        logic [14:0] cw  [3][4] = '{'{15'h6020, 15'h0060, 15'h0084, 15'h0A00},
                                    '{15'h6020, 15'h0060, 15'h00C0, 15'h1400},
                                    '{15'h6020, 15'h0060, 15'h00C0, 15'h0800}};
        bus_if.zero = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus_if.opcode = ops[k];
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (bus_if.state_dbg !== st[k][i]) $display("FAIL op%b_state cyc%0d got %0d exp %0d", ops[k], i, bus_if.state_dbg, st[k][i]);
                else n_pass++;
                n_checks++;
                if (cw_now() !== cw[k][i]) $display("FAIL op%b_cw cyc%0d got %h exp %h", ops[k], i, cw_now(), cw[k][i]);
                else n_pass++;
                tick();
            end
        end
        bus_if.zero = 1'b0;
    endtask

    // Three-cycle control transfers: beq taken, beq not taken, j, and bne when enabled.
`ifdef MC_CTRL_BNE_EN
    localparam int unsigned NBR = 6;
`else
    localparam int unsigned NBR = 3;
`endif
    task automatic test_branch_jump();
`ifdef MC_CTRL_BNE_EN
        logic [5:0]  ops [NBR] = '{6'b000100, 6'b000100, 6'b000010, 6'b000101, 6'b000101, 6'b000010};
        logic        zs  [NBR] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  s3  [NBR] = '{4'd8, 4'd8, 4'd11, 4'd12, 4'd12, 4'd11};
        logic [14:0] c3  [NBR] = '{15'h408A, 15'h008A, 15'h4010, 15'h408A, 15'h008A, 15'h4010};
`else
        logic [5:0]  ops [NBR] = '{6'b000100, 6'b000100, 6'b000010};
        logic        zs  [NBR] = '{1'b1, 1'b0, 1'b1};
        logic [3:0]  s3  [NBR] = '{4'd8, 4'd8, 4'd11};
        logic [14:0] c3  [NBR] = '{15'h408A, 15'h008A, 15'h4010};
`endif
        logic [3:0]  st [3];
        logic [14:0] cw [3];
        for (int k = 0; k < int'(NBR); k++) begin
            bus_if.opcode = ops[k];
            bus_if.zero = zs[k];
            st = '{4'd0, 4'd1, s3[k]};
            cw = '{15'h6020, 15'h0060, c3[k]};
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (bus_if.state_dbg !== st[i]) $display("FAIL br%0d_state cyc%0d got %0d exp %0d", k, i, bus_if.state_dbg, st[i]);
                else n_pass++;
                n_checks++;
                if (cw_now() !== cw[i]) $display("FAIL br%0d_cw cyc%0d got %h exp %h", k, i, cw_now(), cw[i]);
                else n_pass++;
                tick();
            end
        end
        bus_if.zero = 1'b0;
    endtask

    task automatic test_illegal();
`ifdef MC_CTRL_BNE_EN
        logic [5:0] ops [2] = '{6'b111111, 6'b111111};
`else
        logic [5:0] ops [2] = '{6'b111111, 6'b000101};
`endif
        logic [3:0]  st [2] = '{4'd0, 4'd1};
        logic [14:0] cw [2] = '{15'h6020, 15'h0061};
        for (int k = 0; k < 2; k++) begin
            bus_if.opcode = ops[k];
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (bus_if.state_dbg !== st[i]) $display("FAIL ill%b_state cyc%0d got %0d exp %0d", ops[k], i, bus_if.state_dbg, st[i]);
                else n_pass++;
                n_checks++;
                if (cw_now() !== cw[i]) $display("FAIL ill%b_cw cyc%0d got %h exp %h", ops[k], i, cw_now(), cw[i]);
                else n_pass++;
                tick();
            end
        end
        n_checks++;
        if (bus_if.state_dbg !== 4'd0) $display("FAIL ill_return got %0d exp 0", bus_if.state_dbg);
        else n_pass++;
    endtask

    // Reset in MEMRD of a lw abandons it; the following j must run cleanly with no regwrite.
    task automatic test_reset_abort();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd11};
        logic [14:0] cw [3] = '{15'h6020, 15'h0060, 15'h4010};
        bus_if.opcode = 6'b100011;
        tick();
        tick();
        tick();
        n_checks++;
        if (bus_if.state_dbg !== 4'd3) $display("FAIL abort_memrd got %0d exp 3", bus_if.state_dbg);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (cw_now() !== 15'h0000) $display("FAIL abort_gate got %h exp %h", cw_now(), 15'h0000);
        else n_pass++;
        tick();
        n_checks++;
        if (bus_if.state_dbg !== 4'd0) $display("FAIL abort_state got %0d exp 0", bus_if.state_dbg);
        else n_pass++;
        n_checks++;
        if (bus_if.regwrite !== 1'b0) $display("FAIL abort_regwrite got %b exp 0", bus_if.regwrite);
        else n_pass++;
        bus_if.opcode = 6'b000010;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus_if.state_dbg !== st[i]) $display("FAIL abort_j_state cyc%0d got %0d exp %0d", i, bus_if.state_dbg, st[i]);
            else n_pass++;
            n_checks++;
            if (cw_now() !== cw[i]) $display("FAIL abort_j_cw cyc%0d got %h exp %h", i, cw_now(), cw[i]);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        bus_if.opcode = 6'b000000;
        bus_if.zero = 1'b0;
        test_reset();
        test_lw();
        test_four_cycle();
        test_branch_jump();
        test_illegal();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
